time_field_editor: RTL and testbench

Parametrised successor to the clock's hour/minute/second set-position selector. It generalises to NUM_FIELDS editable fields, each with its own wrap limit. It captures the running time on entry to set mode, rotates the edit cursor forward or backward, and increments or decrements the selected field with wrap-around. On exit it commits the edited time with a one-cycle pulse, and it drives a blink mask so the display can flash the selected field. It sits between control_state_machine (set_time_en, button strobes) and the time counter/display path.

---
 rtl/time_field_editor_if.sv | 29 ++
 rtl/time_field_editor.sv | 122 ++++++++++++
 tb/tb_time_field_editor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/time_field_editor_if.sv
// Bundle between the set-mode controller and the time field editor.
// The controller side (master) drives set mode, the button strobes and the
// live time; the editor side (slave) returns cursor, edited value, commit
// pulse and blink mask.
interface time_field_editor_if #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 6
);
    logic                          set_time_en;
    logic                          set_time_shift;
    logic                          set_time_back;
    logic                          inc;
    logic                          dec;
    logic [NUM_FIELDS*FIELD_W-1:0] cur_time;
    logic [NUM_FIELDS-1:0]         field_en;
    logic [NUM_FIELDS*FIELD_W-1:0] set_val;
    logic                          commit;
    logic [NUM_FIELDS-1:0]         blank_mask;

    modport master (
        output set_time_en, set_time_shift, set_time_back, inc, dec, cur_time,
        input  field_en, set_val, commit, blank_mask
    );

    modport slave (
        input  set_time_en, set_time_shift, set_time_back, inc, dec, cur_time,
        output field_en, set_val, commit, blank_mask
    );
endinterface

// File: rtl/time_field_editor.sv
// Set-mode editor for a multi-field time value. Captures the live time on
// entry (clamped to each field's limit), moves a one-hot edit cursor,
// wraps the selected field up/down, pulses commit on exit and produces a
// blink mask so the display can flash the field being edited.
module time_field_editor #(
    parameter int                                  NUM_FIELDS = 3,
    parameter int                                  FIELD_W    = 6,
    parameter logic [NUM_FIELDS*FIELD_W-1:0]       FIELD_MAX  = {6'd23, 6'd59, 6'd59},
    parameter int                                  BLINK_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    time_field_editor_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_FIELDS);
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);

    logic                          en_d_reg;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic [NUM_FIELDS-1:0]         field_en_reg, field_en_next;
    logic [NUM_FIELDS*FIELD_W-1:0] set_val_reg, set_val_next;
    logic                          commit_reg, commit_next;
    logic [NUM_FIELDS-1:0]         blank_reg, blank_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic                          phase_on_reg, phase_on_next;

    logic entry, editing, leaving, any_strobe, inc_only, dec_only;

    assign entry      = bus.set_time_en & ~en_d_reg;
    assign editing    = bus.set_time_en & en_d_reg;
    assign leaving    = ~bus.set_time_en & en_d_reg;
    assign any_strobe = bus.set_time_shift | bus.set_time_back | bus.inc | bus.dec;
    assign inc_only   = bus.inc & ~bus.dec;
    assign dec_only   = bus.dec & ~bus.inc;

    // Cursor index: start at the most significant field, rotate with explicit
    // wrap compares so non-power-of-two field counts behave.
    always_comb begin
        idx_next = idx_reg;
        if (entry) begin
            idx_next = IDX_TOP;
        end else if (editing) begin
            if (bus.set_time_shift && !bus.set_time_back) begin
                idx_next = (idx_reg == '0) ? IDX_TOP : idx_reg - 1'b1;
            end else if (bus.set_time_back && !bus.set_time_shift) begin
                idx_next = (idx_reg == IDX_TOP) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // Per-field cursor decode and value update; edits use the pre-move cursor.
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        localparam logic [FIELD_W-1:0] LIMIT = FIELD_MAX[gi*FIELD_W +: FIELD_W];
        logic [FIELD_W-1:0] live, cur, fld_next;

        assign live = bus.cur_time[gi*FIELD_W +: FIELD_W];
        assign cur  = set_val_reg[gi*FIELD_W +: FIELD_W];
        assign field_en_next[gi] = bus.set_time_en && (idx_next == IDX_W'(gi));
        assign set_val_next[gi*FIELD_W +: FIELD_W] = fld_next;

        // Clamp on capture, wrap on inc/dec of the selected field, else hold.
        always_comb begin
            fld_next = cur;
            if (entry) begin
                fld_next = (live > LIMIT) ? LIMIT : live;
            end else if (editing && (idx_reg == IDX_W'(gi))) begin
                if (inc_only) begin
                    fld_next = (cur == LIMIT) ? '0 : cur + 1'b1;
                end else if (dec_only) begin
                    fld_next = (cur == '0) ? LIMIT : cur - 1'b1;
                end
            end
        end
    end

    // Blink timer: any button activity restarts a visible half-period.
    always_comb begin
        cnt_next      = '0;
        phase_on_next = 1'b1;
        if (editing && !any_strobe) begin
            if (cnt_reg == CNT_TOP) begin
                phase_on_next = ~phase_on_reg;
            end else begin
                cnt_next      = cnt_reg + 1'b1;
                phase_on_next = phase_on_reg;
            end
        end
    end

    assign blank_next  = field_en_next & {NUM_FIELDS{~phase_on_next}};
    assign commit_next = leaving;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d_reg     <= 1'b0;
            idx_reg      <= '0;
            field_en_reg <= '0;
            set_val_reg  <= '0;
            commit_reg   <= 1'b0;
            blank_reg    <= '0;
            cnt_reg      <= '0;
            phase_on_reg <= 1'b1;
        end else begin
            en_d_reg     <= bus.set_time_en;
            idx_reg      <= idx_next;
            field_en_reg <= field_en_next;
            set_val_reg  <= set_val_next;
            commit_reg   <= commit_next;
            blank_reg    <= blank_next;
            cnt_reg      <= cnt_next;
            phase_on_reg <= phase_on_next;
        end
    end

    assign bus.field_en   = field_en_reg;
    assign bus.set_val    = set_val_reg;
    assign bus.commit     = commit_reg;
    assign bus.blank_mask = blank_reg;
endmodule

// File: tb/tb_time_field_editor.sv
// Directed bench for time_field_editor: a 3-field clock build and a 4-field
// day/hour/minute/second build, both with a short blink period.
module tb_time_field_editor;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    time_field_editor_if #(.NUM_FIELDS(3), .FIELD_W(6)) b3 ();
    time_field_editor_if #(.NUM_FIELDS(4), .FIELD_W(6)) b4 ();

    time_field_editor #(
        .NUM_FIELDS(3), .FIELD_W(6),
        .FIELD_MAX({6'd23, 6'd59, 6'd59}), .BLINK_DIV(4)
    ) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );

    time_field_editor #(
        .NUM_FIELDS(4), .FIELD_W(6),
        .FIELD_MAX({6'd9, 6'd23, 6'd59, 6'd59}), .BLINK_DIV(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    function automatic logic [17:0] t3(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    function automatic logic [23:0] t4(input int d, input int h, input int m, input int s);
        return {6'(d), 6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s3(input logic sh, input logic bk, input logic ic, input logic dc);
        b3.set_time_shift = sh; b3.set_time_back = bk; b3.inc = ic; b3.dec = dc;
        tick();
        b3.set_time_shift = 1'b0; b3.set_time_back = 1'b0; b3.inc = 1'b0; b3.dec = 1'b0;
    endtask

    task automatic s4(input logic sh, input logic bk, input logic ic, input logic dc);
        b4.set_time_shift = sh; b4.set_time_back = bk; b4.inc = ic; b4.dec = dc;
        tick();
        b4.set_time_shift = 1'b0; b4.set_time_back = 1'b0; b4.inc = 1'b0; b4.dec = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        b3.set_time_en = 0; b3.set_time_shift = 0; b3.set_time_back = 0;
        b3.inc = 0; b3.dec = 0; b3.cur_time = '0;
        b4.set_time_en = 0; b4.set_time_shift = 0; b4.set_time_back = 0;
        b4.inc = 0; b4.dec = 0; b4.cur_time = '0;
        tick(); tick();
        chk("rst_field_en", 64'(b3.field_en), 64'd0);
        chk("rst_set_val", 64'(b3.set_val), 64'd0);
        chk("rst_commit", 64'(b3.commit), 64'd0);
        chk("rst_blank", 64'(b3.blank_mask), 64'd0);
        chk("rst4_field_en", 64'(b4.field_en), 64'd0);
        rst = 1'b0;
        tick();

        // Entry
        b3.cur_time = t3(23, 59, 59);
        b3.set_time_en = 1'b1;
        tick();
        chk("entry_field_en", 64'(b3.field_en), 64'b100);
        chk("entry_set_val", 64'(b3.set_val), 64'(t3(23, 59, 59)));
        chk("entry_blank", 64'(b3.blank_mask), 64'd0);
        chk("entry_commit", 64'(b3.commit), 64'd0);

        // Inc/dec wrap
        s3(0, 0, 1, 0); chk("hour_inc_wrap", 64'(b3.set_val), 64'(t3(0, 59, 59)));
        s3(0, 0, 0, 1); chk("hour_dec_wrap", 64'(b3.set_val), 64'(t3(23, 59, 59)));
        s3(1, 0, 0, 0); chk("shift_to_min", 64'(b3.field_en), 64'b010);
        s3(0, 0, 1, 0); chk("min_inc_wrap", 64'(b3.set_val), 64'(t3(23, 0, 59)));
        s3(0, 0, 0, 1); chk("min_dec_wrap", 64'(b3.set_val), 64'(t3(23, 59, 59)));

        // Cursor
        s3(1, 0, 0, 0); chk("shift_to_sec", 64'(b3.field_en), 64'b001);
        s3(1, 0, 0, 0); chk("shift_wrap", 64'(b3.field_en), 64'b100);
        s3(0, 1, 0, 0); chk("back_wrap", 64'(b3.field_en), 64'b001);
        s3(1, 1, 0, 0); chk("shift_back_hold", 64'(b3.field_en), 64'b001);
        s3(0, 0, 1, 1); chk("inc_dec_hold", 64'(b3.set_val), 64'(t3(23, 59, 59)));
        s3(1, 0, 1, 0);
        chk("inc_shift_val", 64'(b3.set_val), 64'(t3(23, 59, 0)));
        chk("inc_shift_cur", 64'(b3.field_en), 64'b100);

        // Edit to 12:34:56
        for (int i = 0; i < 11; i++) s3(0, 0, 0, 1);
        s3(1, 0, 0, 0);
        for (int i = 0; i < 25; i++) s3(0, 0, 0, 1);
        s3(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) s3(0, 0, 0, 1);
        chk("edit_val", 64'(b3.set_val), 64'(t3(12, 34, 56)));
        chk("edit_blank", 64'(b3.blank_mask), 64'd0);

        // Blink: last strobe restarted a visible half-period
        tick(); tick(); tick();
        chk("blink_on_3", 64'(b3.blank_mask), 64'd0);
        tick();
        chk("blink_off_4", 64'(b3.blank_mask), 64'b001);
        tick(); tick(); tick();
        chk("blink_off_7", 64'(b3.blank_mask), 64'b001);
        tick();
        chk("blink_on_8", 64'(b3.blank_mask), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("blink_off_13", 64'(b3.blank_mask), 64'b001);
        s3(0, 0, 1, 0);
        chk("inc_forces_on", 64'(b3.blank_mask), 64'd0);
        chk("inc_in_blink", 64'(b3.set_val), 64'(t3(12, 34, 57)));
        tick(); tick(); tick();
        chk("restart_on_3", 64'(b3.blank_mask), 64'd0);
        tick();
        chk("restart_off_4", 64'(b3.blank_mask), 64'b001);
        s3(0, 0, 0, 1);
        chk("dec_restore", 64'(b3.set_val), 64'(t3(12, 34, 56)));

        // Commit
        b3.set_time_en = 1'b0;
        tick();
        chk("commit_pulse", 64'(b3.commit), 64'd1);
        chk("commit_val", 64'(b3.set_val), 64'(t3(12, 34, 56)));
        chk("commit_field_en", 64'(b3.field_en), 64'd0);
        chk("commit_blank", 64'(b3.blank_mask), 64'd0);
        tick();
        chk("commit_one_cycle", 64'(b3.commit), 64'd0);
        s3(1, 0, 1, 0);
        s3(0, 1, 0, 1);
        chk("idle_val_hold", 64'(b3.set_val), 64'(t3(12, 34, 56)));
        chk("idle_field_en", 64'(b3.field_en), 64'd0);
        chk("idle_commit", 64'(b3.commit), 64'd0);

        // Clamp on entry, then exit and immediate re-entry
        b3.cur_time = t3(31, 63, 40);
        b3.set_time_en = 1'b1;
        tick();
        chk("clamp_val", 64'(b3.set_val), 64'(t3(23, 59, 40)));
        b3.set_time_en = 1'b0;
        tick();
        chk("reexit_commit", 64'(b3.commit), 64'd1);
        b3.cur_time = t3(1, 2, 3);
        b3.set_time_en = 1'b1;
        tick();
        chk("reentry_commit", 64'(b3.commit), 64'd0);
        chk("reentry_cur", 64'(b3.field_en), 64'b100);
        chk("reentry_val", 64'(b3.set_val), 64'(t3(1, 2, 3)));

        // Reset mid-edit
        s3(0, 0, 1, 0);
        chk("pre_rst_val", 64'(b3.set_val), 64'(t3(2, 2, 3)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_field_en", 64'(b3.field_en), 64'd0);
        chk("async_rst_val", 64'(b3.set_val), 64'd0);
        b3.set_time_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_commit", 64'(b3.commit), 64'd0);
        chk("post_rst_val", 64'(b3.set_val), 64'd0);
        tick();
        chk("post_rst_commit2", 64'(b3.commit), 64'd0);

        // Four-field build
        b4.cur_time = t4(9, 5, 6, 7);
        b4.set_time_en = 1'b1;
        tick();
        chk("f4_entry_cur", 64'(b4.field_en), 64'b1000);
        chk("f4_entry_val", 64'(b4.set_val), 64'(t4(9, 5, 6, 7)));
        s4(0, 0, 1, 0); chk("f4_day_inc_wrap", 64'(b4.set_val), 64'(t4(0, 5, 6, 7)));
        s4(0, 0, 0, 1); chk("f4_day_dec_wrap", 64'(b4.set_val), 64'(t4(9, 5, 6, 7)));
        s4(0, 1, 0, 0); chk("f4_back_wrap", 64'(b4.field_en), 64'b0001);
        s4(1, 0, 0, 0); chk("f4_shift_wrap", 64'(b4.field_en), 64'b1000);
        s4(1, 0, 0, 0); chk("f4_shift_2", 64'(b4.field_en), 64'b0100);
        s4(1, 0, 0, 0);
        s4(1, 0, 0, 0); chk("f4_shift_0", 64'(b4.field_en), 64'b0001);
        b4.set_time_en = 1'b0;
        tick();
        chk("f4_commit", 64'(b4.commit), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
